// File: rtl/rc_seq_ctrl_if.sv
// Requester-side handshake bundle for the ripple-counter sequencer.
interface rc_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] target;
  logic             stop;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count_out;
  logic             stopped;
  logic             error;

  modport master (
    output start, target, stop,
    input  busy, done, count_out, stopped, error
  );

  modport slave (
    input  start, target, stop,
    output busy, done, count_out, stopped, error
  );
endinterface

// File: rtl/rc_seq_ctrl.sv
// Sequencer for the asynchronous ripple counter: clears it, issues a
// programmed number of clock pulses, lets each ripple settle, and checks
// the sampled count against a shadow count. All outputs are registered.
module rc_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  rc_seq_ctrl_if.slave     bus,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_clk,
  output logic             cnt_reset
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PULSE_H,
    SETTLE_L,
    CHECK,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nx;
  logic [SW-1:0]    settle_cnt;
  logic             clr_phase;
  logic             stop_req;

  // Shadow count the counter should show after the pulse just issued.
  always_comb shadow_nx = shadow + WIDTH'(1);

  // Sequencer FSM; outputs are assigned alongside the transition that
  // enters the state they belong to, so they are valid in that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tgt_r         <= '0;
      shadow        <= '0;
      settle_cnt    <= '0;
      clr_phase     <= 1'b0;
      stop_req      <= 1'b0;
      cnt_clk       <= 1'b0;
      cnt_reset     <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.count_out <= '0;
      bus.stopped   <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      cnt_clk   <= 1'b0;
      cnt_reset <= 1'b0;
      bus.done  <= 1'b0;
      if (state != IDLE && bus.stop)
        stop_req <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.start) begin
            tgt_r         <= bus.target;
            shadow        <= '0;
            bus.stopped   <= 1'b0;
            bus.error     <= 1'b0;
            bus.count_out <= '0;
            stop_req      <= 1'b0;
            clr_phase     <= 1'b0;
            cnt_reset     <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= CLEAR;
          end
        end

        CLEAR: begin
          if (!clr_phase) begin
            clr_phase <= 1'b1;
            cnt_reset <= 1'b1;
          end else if (tgt_r == '0) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            cnt_clk <= 1'b1;
            state   <= PULSE_H;
          end
        end

        PULSE_H: begin
          settle_cnt <= '0;
          state      <= SETTLE_L;
        end

        SETTLE_L: begin
          if (settle_cnt == SW'(SETTLE - 1))
            state <= CHECK;
          else
            settle_cnt <= settle_cnt + SW'(1);
        end

        CHECK: begin
          bus.count_out <= cnt_q;
          shadow        <= shadow_nx;
          if (cnt_q != shadow_nx) begin
            bus.error <= 1'b1;
            bus.done  <= 1'b1;
            state     <= DONE;
          end else if (shadow_nx == tgt_r) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else if (stop_req) begin
            bus.stopped <= 1'b1;
            bus.done    <= 1'b1;
            state       <= DONE;
          end else begin
            cnt_clk <= 1'b1;
            state   <= PULSE_H;
          end
        end

        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc_seq_ctrl.sv
// Directed bench for rc_seq_ctrl with a behavioural ripple-counter model.
module tb_rc_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cnt_clk;
  logic        cnt_reset;
  logic [15:0] cnt_q;
  logic [15:0] model = '0;
  logic        fault = 1'b0;
  int          tests = 0;
  int          fails = 0;

  rc_seq_ctrl_if #(.WIDTH(16)) ifc ();

  rc_seq_ctrl #(.WIDTH(16), .SETTLE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (ifc),
    .cnt_q    (cnt_q),
    .cnt_clk  (cnt_clk),
    .cnt_reset(cnt_reset)
  );

  always #5 clk = ~clk;

  // Ideal ripple counter: advances on the falling edge of its clock.
  always @(negedge cnt_clk or posedge cnt_reset)
    if (cnt_reset) model <= '0;
    else           model <= model + 16'd1;

  assign cnt_q = fault ? (model & 16'hFFFD) : model;

  // Runs one transaction; cycle n is the period after the (n-1)th edge
  // following acceptance. Returns observations up to the cycle after done.
  task automatic do_run(input logic [15:0] tgt, input int stop_cyc,
                        input int start2_cyc, input int limit,
                        output int done_cyc, output int npulse,
                        output logic [3:0] crst, output logic busy_after);
    int   cyc;
    logic prev;
    done_cyc = -1; npulse = 0; crst = '0; busy_after = 1'b1; prev = 1'b0;
    @(negedge clk);
    ifc.start = 1'b1; ifc.target = tgt;
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.target = 16'hA5A5;
    cyc = 1;
    while (cyc <= limit) begin
      if (cyc < 4) crst[cyc] = cnt_reset;
      if (cnt_clk && !prev) npulse++;
      prev = cnt_clk;
      if (ifc.done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = ifc.busy;
        break;
      end
      ifc.stop  = (cyc == stop_cyc);
      ifc.start = (cyc == start2_cyc);
      if (cyc == start2_cyc) ifc.target = 16'd1;
      @(posedge clk); #1;
      cyc++;
    end
    ifc.stop = 1'b0; ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    tests++; if (ifc.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", ifc.done); end
    tests++; if (cnt_clk !== 1'b0) begin fails++; $display("FAIL reset_cnt_clk got=%b exp=0", cnt_clk); end
    tests++; if (cnt_reset !== 1'b1) begin fails++; $display("FAIL reset_cnt_reset got=%b exp=1", cnt_reset); end
    tests++; if (ifc.count_out !== 16'h0000) begin fails++; $display("FAIL reset_count got=%h exp=0000", ifc.count_out); end
    tests++; if ({ifc.stopped, ifc.error} !== 2'b00) begin fails++; $display("FAIL reset_flags got=%b exp=00", {ifc.stopped, ifc.error}); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (cnt_reset !== 1'b0) begin fails++; $display("FAIL reset_release_cnt_reset got=%b exp=0", cnt_reset); end
  endtask

  task automatic test_basic();
    int dc, np; logic [3:0] cr; logic ba;
    do_run(16'd3, -1, -1, 30, dc, np, cr, ba);
    tests++; if (dc !== 21) begin fails++; $display("FAIL basic_done_cycle got=%0d exp=21", dc); end
    tests++; if (np !== 3) begin fails++; $display("FAIL basic_pulses got=%0d exp=3", np); end
    tests++; if (ifc.count_out !== 16'd3) begin fails++; $display("FAIL basic_count got=%h exp=0003", ifc.count_out); end
    tests++; if ({ifc.stopped, ifc.error} !== 2'b00) begin fails++; $display("FAIL basic_flags got=%b exp=00", {ifc.stopped, ifc.error}); end
    tests++; if (ba !== 1'b0) begin fails++; $display("FAIL basic_busy_after got=%b exp=0", ba); end
    tests++; if (cr[3:1] !== 3'b011) begin fails++; $display("FAIL basic_cnt_reset got=%b exp=011", cr[3:1]); end
  endtask

  task automatic test_zero_target();
    int dc, np; logic [3:0] cr; logic ba;
    do_run(16'd0, -1, -1, 10, dc, np, cr, ba);
    tests++; if (dc !== 3) begin fails++; $display("FAIL zero_done_cycle got=%0d exp=3", dc); end
    tests++; if (np !== 0) begin fails++; $display("FAIL zero_pulses got=%0d exp=0", np); end
    tests++; if (cr[2:1] !== 2'b11) begin fails++; $display("FAIL zero_cnt_reset got=%b exp=11", cr[2:1]); end
    tests++; if (ifc.count_out !== 16'd0) begin fails++; $display("FAIL zero_count got=%h exp=0000", ifc.count_out); end
    tests++; if (ba !== 1'b0) begin fails++; $display("FAIL zero_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_stop();
    int dc, np; logic [3:0] cr; logic ba;
    // stop held high while idle must not leak into the next run
    @(negedge clk); ifc.stop = 1'b1;
    repeat (2) @(negedge clk);
    ifc.stop = 1'b0;
    do_run(16'd10, 9, -1, 30, dc, np, cr, ba);
    tests++; if (dc !== 15) begin fails++; $display("FAIL stop_done_cycle got=%0d exp=15", dc); end
    tests++; if (ifc.count_out !== 16'd2) begin fails++; $display("FAIL stop_count got=%h exp=0002", ifc.count_out); end
    tests++; if (ifc.stopped !== 1'b1) begin fails++; $display("FAIL stop_stopped got=%b exp=1", ifc.stopped); end
    tests++; if (ifc.error !== 1'b0) begin fails++; $display("FAIL stop_error got=%b exp=0", ifc.error); end
  endtask

  task automatic test_stop_at_target();
    int dc, np; logic [3:0] cr; logic ba;
    do_run(16'd2, 9, -1, 30, dc, np, cr, ba);
    tests++; if (dc !== 15) begin fails++; $display("FAIL stoptgt_done_cycle got=%0d exp=15", dc); end
    tests++; if (ifc.stopped !== 1'b0) begin fails++; $display("FAIL stoptgt_stopped got=%b exp=0", ifc.stopped); end
    tests++; if (ifc.count_out !== 16'd2) begin fails++; $display("FAIL stoptgt_count got=%h exp=0002", ifc.count_out); end
  endtask

  task automatic test_error();
    int dc, np; logic [3:0] cr; logic ba;
    fault = 1'b1;
    do_run(16'd5, -1, -1, 40, dc, np, cr, ba);
    fault = 1'b0;
    tests++; if (dc !== 15) begin fails++; $display("FAIL error_done_cycle got=%0d exp=15", dc); end
    tests++; if (ifc.error !== 1'b1) begin fails++; $display("FAIL error_flag got=%b exp=1", ifc.error); end
    tests++; if (ifc.count_out !== 16'h0000) begin fails++; $display("FAIL error_count got=%h exp=0000", ifc.count_out); end
    tests++; if (ifc.stopped !== 1'b0) begin fails++; $display("FAIL error_stopped got=%b exp=0", ifc.stopped); end
    tests++; if (np !== 2) begin fails++; $display("FAIL error_pulses got=%0d exp=2", np); end
  endtask

  task automatic test_full_width_target();
    int dc, np; logic [3:0] cr; logic ba;
    do_run(16'hFFFF, 4, -1, 20, dc, np, cr, ba);
    tests++; if (dc !== 9) begin fails++; $display("FAIL ffff_done_cycle got=%0d exp=9", dc); end
    tests++; if ({ifc.stopped, ifc.error} !== 2'b10) begin fails++; $display("FAIL ffff_flags got=%b exp=10", {ifc.stopped, ifc.error}); end
    tests++; if (ifc.count_out !== 16'd1) begin fails++; $display("FAIL ffff_count got=%h exp=0001", ifc.count_out); end
  endtask

  task automatic test_back_to_back();
    int dc, np; logic [3:0] cr; logic ba;
    do_run(16'h2000, -1, 100, 49200, dc, np, cr, ba);
    tests++; if (dc !== 3 + 8192 * 6) begin fails++; $display("FAIL long_done_cycle got=%0d exp=%0d", dc, 3 + 8192 * 6); end
    tests++; if (np !== 8192) begin fails++; $display("FAIL long_pulses got=%0d exp=8192", np); end
    tests++; if (ifc.count_out !== 16'h2000) begin fails++; $display("FAIL long_count got=%h exp=2000", ifc.count_out); end
    tests++; if ({ifc.stopped, ifc.error} !== 2'b00) begin fails++; $display("FAIL long_flags got=%b exp=00", {ifc.stopped, ifc.error}); end
    tests++; if (ba !== 1'b0) begin fails++; $display("FAIL long_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_async_reset();
    int dc, np; logic [3:0] cr; logic ba; logic saw_done;
    @(negedge clk); ifc.start = 1'b1; ifc.target = 16'd8;
    @(posedge clk); #1; ifc.start = 1'b0;
    repeat (22) @(posedge clk);
    #2;
    // now in cycle 23: SETTLE_L of pulse 4
    tests++; if (model !== 16'd4) begin fails++; $display("FAIL areset_pre_count got=%0d exp=4", model); end
    reset = 1'b1; #1;
    tests++; if ({ifc.busy, ifc.done, cnt_clk} !== 3'b000) begin fails++; $display("FAIL areset_outputs got=%b exp=000", {ifc.busy, ifc.done, cnt_clk}); end
    tests++; if (cnt_reset !== 1'b1) begin fails++; $display("FAIL areset_cnt_reset got=%b exp=1", cnt_reset); end
    saw_done = 1'b0;
    repeat (2) begin @(posedge clk); #1; saw_done |= ifc.done; end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; saw_done |= ifc.done;
    tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL areset_no_done got=%b exp=0", saw_done); end
    tests++; if ({cnt_reset, ifc.busy} !== 2'b00) begin fails++; $display("FAIL areset_release got=%b exp=00", {cnt_reset, ifc.busy}); end
    do_run(16'd2, -1, -1, 30, dc, np, cr, ba);
    tests++; if (dc !== 15) begin fails++; $display("FAIL areset_rerun_done got=%0d exp=15", dc); end
    tests++; if ({ifc.count_out, ifc.error} !== {16'd2, 1'b0}) begin fails++; $display("FAIL areset_rerun got=%h/%b exp=0002/0", ifc.count_out, ifc.error); end
  endtask

  initial begin
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.target = '0;
    #12;
    test_reset();
    test_basic();
    test_zero_target();
    test_stop();
    test_stop_at_target();
    test_error();
    test_full_width_target();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
